// File: rtl/spi_reg_ctrl.sv
// Byte command decoder for an SPI slave that reads and writes an 8-bit register file and queues one reply byte.
// Latency: every action lands one cycle after the rx strobe. No backpressure; each rx strobe yields at most one tx load.
module spi_reg_ctrl #(
  parameter int         NUM_REGS  = 8,
  parameter logic [7:0] ID_VALUE  = 8'hA7,
  parameter logic [7:0] REG_RESET = 8'h00,
  parameter logic [7:0] ACK_VALUE = 8'h5A,
  parameter logic [7:0] NAK_VALUE = 8'hEE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            spi_rx_data,
  input  logic                  spi_rx_valid,
  input  logic                  spi_busy,
  output logic [7:0]            spi_tx_data,
  output logic                  spi_tx_valid,
  output logic [8*NUM_REGS-1:0] reg_q,
  output logic                  reg_wr_stb,
  output logic [6:0]            reg_wr_addr,
  output logic [7:0]            err_count
);

  typedef enum logic {IDLE, WDATA} state_t;

  localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

  state_t     state, state_nxt;
  logic [7:0] regs [NUM_REGS];
  logic       busy_q;
  logic       frame_end;
  logic       cmd_wr;
  logic [6:0] cmd_addr;
  logic       addr_ok;
  logic [7:0] rd_dat;
  logic [6:0] waddr, waddr_nxt;
  logic [7:0] tx_dat_nxt;
  logic       tx_vld_nxt;
  logic       wr_en;
  logic       err_inc;

  // CS rising edge marks the end of a host frame.
  assign frame_end = spi_busy & ~busy_q;
  assign cmd_wr    = spi_rx_data[7];
  assign cmd_addr  = spi_rx_data[6:0];
  assign addr_ok   = ({1'b0, cmd_addr} < NUM_REGS_B);

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr == 7'(i)) rd_dat = regs[i];
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      reg_q[8*i +: 8] = regs[i];
    end
  end

  always_comb begin
    state_nxt  = state;
    waddr_nxt  = waddr;
    tx_dat_nxt = spi_tx_data;
    tx_vld_nxt = 1'b0;
    wr_en      = 1'b0;
    err_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (spi_rx_valid) begin
          tx_vld_nxt = 1'b1;
          if (!cmd_wr && addr_ok) begin
            tx_dat_nxt = rd_dat;
          end else if (cmd_wr && addr_ok && !frame_end) begin
            tx_vld_nxt = 1'b0;
            waddr_nxt  = cmd_addr;
            state_nxt  = WDATA;
          end else begin
            // Bad address, or a write command whose frame closes on the same cycle.
            tx_dat_nxt = NAK_VALUE;
            err_inc    = 1'b1;
          end
        end
      end
      WDATA: begin
        if (spi_rx_valid) begin
          wr_en      = 1'b1;
          tx_vld_nxt = 1'b1;
          tx_dat_nxt = ACK_VALUE;
          state_nxt  = IDLE;
        end else if (frame_end) begin
          tx_vld_nxt = 1'b1;
          tx_dat_nxt = NAK_VALUE;
          err_inc    = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy_q       <= 1'b1;
      waddr        <= '0;
      spi_tx_data  <= '0;
      spi_tx_valid <= 1'b0;
      reg_wr_stb   <= 1'b0;
      reg_wr_addr  <= '0;
      err_count    <= '0;
    end else begin
      state        <= state_nxt;
      busy_q       <= spi_busy;
      waddr        <= waddr_nxt;
      spi_tx_data  <= tx_dat_nxt;
      spi_tx_valid <= tx_vld_nxt;
      reg_wr_stb   <= wr_en;
      if (wr_en) reg_wr_addr <= waddr;
      if (err_inc && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  // Reg 0 holds the ID and ignores writes; the write is still acknowledged.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        regs[i] <= (i == 0) ? ID_VALUE : REG_RESET;
      end else if (wr_en && i != 0 && waddr == 7'(i)) begin
        regs[i] <= spi_rx_data;
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl with scoreboard queues for reply bytes and write strobes.
module tb_spi_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  spi_rx_data;
  logic        spi_rx_valid;
  logic        spi_busy;
  logic [7:0]  spi_tx_data;
  logic        spi_tx_valid;
  logic [63:0] reg_q;
  logic        reg_wr_stb;
  logic [6:0]  reg_wr_addr;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_tx [$];
  logic [6:0] exp_wr [$];
  logic [7:0] last_load = 8'h00;
  logic [7:0] miso_byte = 8'h00;
  logic       busy_prev = 1'b1;

  spi_reg_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .spi_rx_data  (spi_rx_data),
    .spi_rx_valid (spi_rx_valid),
    .spi_busy     (spi_busy),
    .spi_tx_data  (spi_tx_data),
    .spi_tx_valid (spi_tx_valid),
    .reg_q        (reg_q),
    .reg_wr_stb   (reg_wr_stb),
    .reg_wr_addr  (reg_wr_addr),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Slave-side model: the byte shifted out in a frame is the last load before CS fell.
  always @(negedge clk) begin
    if (!spi_busy && busy_prev) miso_byte = last_load;
    busy_prev = spi_busy;
    if (spi_tx_valid) begin
      logic [8:0] e;
      last_load = spi_tx_data;
      e = (exp_tx.size() > 0) ? {1'b1, exp_tx.pop_front()} : 9'h000;
      chk("tx_byte", {55'd0, 1'b1, spi_tx_data}, {55'd0, e});
    end
    if (reg_wr_stb) begin
      logic [7:0] w;
      w = (exp_wr.size() > 0) ? {1'b1, exp_wr.pop_front()} : 8'h00;
      chk("wr_addr", {56'd0, 1'b1, reg_wr_addr}, {56'd0, w});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    spi_rx_data  = b;
    spi_rx_valid = 1'b1;
    @(posedge clk); #1;
    spi_rx_valid = 1'b0;
  endtask

  // Final byte of a frame arrives in the same cycle CS rises.
  task automatic send_last(input logic [7:0] b);
    @(posedge clk); #1;
    spi_rx_data  = b;
    spi_rx_valid = 1'b1;
    spi_busy     = 1'b1;
    @(posedge clk); #1;
    spi_rx_valid = 1'b0;
  endtask

  task automatic cs(input logic low);
    @(posedge clk); #1;
    spi_busy = ~low;
  endtask

  initial begin
    rst = 1'b1; spi_rx_data = 8'h00; spi_rx_valid = 1'b0; spi_busy = 1'b1;
    idle(3);
    chk("rst_reg_q", reg_q, 64'h0000_0000_0000_00A7);
    chk("rst_tx_valid", {63'd0, spi_tx_valid}, 64'd0);
    chk("rst_tx_data", {56'd0, spi_tx_data}, 64'd0);
    chk("rst_err", {56'd0, err_count}, 64'd0);
    chk("rst_wr", {56'd0, reg_wr_stb, reg_wr_addr}, 64'd0);
    rst = 1'b0;
    idle(2);

    // Write reg3, then read it back across frames.
    cs(1); exp_wr.push_back(7'd3); exp_tx.push_back(8'h5A);
    send(8'h83); send(8'h3C); cs(0); idle(3);
    chk("reg3", {56'd0, reg_q[31:24]}, 64'h3C);
    cs(1); exp_tx.push_back(8'h3C); send(8'h03); cs(0); idle(2);
    cs(1); idle(1);
    chk("miso_read", {56'd0, miso_byte}, 64'h3C);
    exp_tx.push_back(8'hA7); send(8'h00); cs(0); idle(2);

    // Reg 0 write is acked but ignored.
    cs(1); exp_wr.push_back(7'd0); exp_tx.push_back(8'h5A);
    send(8'h80); send(8'h11); cs(0); idle(3);
    chk("reg0_ro", {56'd0, reg_q[7:0]}, 64'hA7);

    // Bad addresses.
    cs(1); exp_tx.push_back(8'hEE); send(8'h09); idle(2);
    chk("err_bad_rd", {56'd0, err_count}, 64'd1);
    exp_tx.push_back(8'hEE); send(8'h8A); cs(0); idle(2);
    chk("err_bad_wr", {56'd0, err_count}, 64'd2);

    // Write aborted by frame end; FSM must be back in IDLE.
    cs(1); send(8'h85); exp_tx.push_back(8'hEE); cs(0); idle(3);
    chk("err_abort", {56'd0, err_count}, 64'd3);
    chk("reg5_kept", {56'd0, reg_q[47:40]}, 64'h00);
    cs(1); exp_tx.push_back(8'h00); send(8'h05); cs(0); idle(2);

    // Data strobe coincides with frame end: write completes.
    cs(1); send(8'h86); exp_wr.push_back(7'd6); exp_tx.push_back(8'h5A);
    send_last(8'h77); idle(3);
    chk("reg6_edge", {56'd0, reg_q[55:48]}, 64'h77);
    chk("err_edge", {56'd0, err_count}, 64'd3);

    // Write command coincides with frame end: aborted.
    cs(1); exp_tx.push_back(8'hEE); send_last(8'h84); idle(3);
    chk("err_cmd_edge", {56'd0, err_count}, 64'd4);
    chk("reg4_kept", {56'd0, reg_q[39:32]}, 64'h00);

    // Reset in WDATA drops the pending write.
    cs(1); send(8'h82);
    rst = 1'b1; idle(2); rst = 1'b0; idle(1);
    chk("rst_mid_regs", reg_q, 64'h0000_0000_0000_00A7);
    chk("rst_mid_err", {56'd0, err_count}, 64'd0);
    exp_tx.push_back(8'h00); send(8'h02); idle(2);
    chk("reg2_reset", {56'd0, reg_q[23:16]}, 64'h00);

    // Saturation of the error counter.
    for (int i = 0; i < 254; i++) begin
      exp_tx.push_back(8'hEE); send(8'h7F);
    end
    idle(2);
    chk("err_254", {56'd0, err_count}, 64'hFE);
    for (int i = 0; i < 6; i++) begin
      exp_tx.push_back(8'hEE); send(8'h7F);
    end
    cs(0); idle(3);
    chk("err_sat", {56'd0, err_count}, 64'hFF);

    chk("tx_queue_drained", 64'(exp_tx.size()), 64'd0);
    chk("wr_queue_drained", 64'(exp_wr.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
